// File: rtl/timing_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// timingPkg
//   Shared definitions for the timing link (serializer and deserializer):
//   word width, number of bit-pair cycles per word, the two K28.5 comma
//   encodings, the alignment FSM state type, and a comma-match helper.
// ---------------------------------------------------------------------------
package timingPkg;

  localparam int TIMING_WORD_W = 10;
  localparam int TIMING_PHASES = 5;

  localparam logic [TIMING_WORD_W-1:0] K28P5_RDN = 10'b0011111010;
  localparam logic [TIMING_WORD_W-1:0] K28P5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  // True when the window holds K28.5 of either running disparity.
  function automatic logic is_k28p5(input logic [TIMING_WORD_W-1:0] w);
    return (w == K28P5_RDN) || (w == K28P5_RDP);
  endfunction

endpackage

// File: rtl/timing_deserializer_comma_detect.sv
// ---------------------------------------------------------------------------
// timingCommaDetect
//   Purely combinational K28.5 detector for one 10-bit candidate window.
//   Ports:
//     i_window : candidate word, bit 9 is the earliest bit on the wire
//     hit      : window equals K28.5 (RD- or RD+)
// ---------------------------------------------------------------------------
module timingCommaDetect
  import timingPkg::*;
(
  input  logic [TIMING_WORD_W-1:0] i_window,
  output logic                     hit
);

  assign hit = is_k28p5(i_window);

endmodule

// File: rtl/timing_deserializer.sv
// ---------------------------------------------------------------------------
// timing_deserializer
//   Rebuilds 10-bit timing words from the recovered bitstream delivered as
//   bit pairs, one pair per clk_ser cycle. Word alignment is found by K28.5
//   comma detection on two candidate windows (even / odd bit boundary) and
//   tracked by a HUNT -> VERIFY -> LOCKED state machine. While locked one
//   word is emitted every TIMING_PHASES cycles.
//
//   Parameters:
//     LOCK_COUNT   : consecutive aligned commas needed to lock (1..15)
//     UNLOCK_COUNT : mis-aligned commas while locked that force re-hunt (1..15)
//
//   Ports:
//     clk_ser     : bit-pair clock
//     reset       : synchronous, active-high
//     serInPair   : [1] earlier bit, [0] later bit
//     parOutWord  : recovered word, bit 9 first received; holds between strobes
//     parOutValid : one-cycle strobe qualifying parOutWord
//     locked      : alignment FSM is in LOCKED
//     isComma     : qualifies parOutValid; emitted word is K28.5
//     misalignCnt : saturating count of mis-aligned commas while locked,
//                   present only when TIMING_DESER_ERRCNT_EN is defined
//
//   Optional feature macro: TIMING_DESER_ERRCNT_EN
// ---------------------------------------------------------------------------
module timing_deserializer
  import timingPkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4
)
(
  input  logic                     clk_ser,
  input  logic                     reset,
  input  logic [1:0]               serInPair,
  output logic [TIMING_WORD_W-1:0] parOutWord,
  output logic                     parOutValid,
  output logic                     locked,
  output logic                     isComma
`ifdef TIMING_DESER_ERRCNT_EN
  ,
  output logic [15:0]              misalignCnt
`endif
);

  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_COUNT);
  localparam logic [2:0] LAST_PHASE = 3'(TIMING_PHASES - 1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [11:0]              r_sr;
  align_state_t             r_state;
  logic                     r_sel;
  logic [2:0]               r_phase;
  logic [3:0]               r_good_cnt;
  logic [3:0]               r_bad_cnt;
  logic [TIMING_WORD_W-1:0] r_word;
  logic                     r_valid;
  logic                     r_locked;
  logic                     r_is_comma;

  // -------------------------------------------------------------------------
  // Next-state / combinational signals
  // -------------------------------------------------------------------------
  align_state_t             w_state_next;
  logic                     w_sel_next;
  logic [2:0]               w_phase_next;
  logic [3:0]               w_good_next;
  logic [3:0]               w_bad_next;
  logic                     w_emit;
  logic [TIMING_WORD_W-1:0] w_emit_word;
  logic                     w_emit_comma;

  logic [TIMING_WORD_W-1:0] w_win [2];
  logic [1:0]               w_hit;
  logic                     w_boundary;
  logic                     w_hit_sel;
  logic                     w_aligned;
  logic                     w_mis0;
  logic                     w_mis1;
  logic                     w_mis_any;
  logic                     w_mis_sel;
  logic                     w_hunt_sel;
  logic [3:0]               w_good_inc;
  logic [3:0]               w_bad_inc;
  logic                     w_unused_sr_msb;

  // Only bits [10:0] feed a window; the top bit is kept for a full 12-bit
  // history but never examined.
  assign w_unused_sr_msb = r_sr[11];

  // -------------------------------------------------------------------------
  // Bit-pair shift register: earlier bit enters first, so the newest bit
  // always sits at r_sr[0].
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_ser) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[9:0], serInPair[1], serInPair[0]};
    end
  end

  // -------------------------------------------------------------------------
  // Candidate windows: gi=0 ends at the newest bit, gi=1 ends one bit
  // earlier (odd boundary).
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_det
      assign w_win[gi] = r_sr[gi +: TIMING_WORD_W];
      timingCommaDetect u_comma_detect (
        .i_window (w_win[gi]),
        .hit      (w_hit[gi])
      );
    end
  endgenerate

  assign w_boundary = (r_phase == 3'd0);
  assign w_hit_sel  = w_hit[r_sel];
  assign w_aligned  = w_boundary && w_hit_sel;

  // A hit is mis-aligned unless it is in the selected window on a boundary.
  assign w_mis0     = w_hit[0] && !(w_boundary && (r_sel == 1'b0));
  assign w_mis1     = w_hit[1] && !(w_boundary && (r_sel == 1'b1));
  // A correctly aligned comma in the same cycle overrides any mis-aligned one.
  assign w_mis_any  = (w_mis0 || w_mis1) && !w_aligned;
  assign w_mis_sel  = w_mis0 ? 1'b0 : 1'b1;

  // Even window wins when both match at once.
  assign w_hunt_sel = w_hit[0] ? 1'b0 : 1'b1;

  assign w_good_inc = r_good_cnt + 4'd1;
  assign w_bad_inc  = r_bad_cnt + 4'd1;

  // -------------------------------------------------------------------------
  // Alignment FSM: next state, counters and word emission
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_phase_next = (r_phase == LAST_PHASE) ? 3'd0 : r_phase + 3'd1;
    w_good_next  = r_good_cnt;
    w_bad_next   = r_bad_cnt;
    w_emit       = 1'b0;
    w_emit_word  = w_win[r_sel];
    w_emit_comma = w_hit_sel;

    case (r_state)
      HUNT: begin
        if (w_hit[0] || w_hit[1]) begin
          // The comma cycle itself is boundary 0 of the new alignment.
          w_sel_next   = w_hunt_sel;
          w_phase_next = 3'd1;
          w_good_next  = 4'd1;
          if (LOCK_COUNT == 1) begin
            w_state_next = LOCKED;
            w_emit       = 1'b1;
            w_emit_word  = w_win[w_hunt_sel];
            w_emit_comma = 1'b1;
          end else begin
            w_state_next = VERIFY;
          end
        end
      end

      VERIFY: begin
        if (w_aligned) begin
          w_good_next = w_good_inc;
          if (w_good_inc >= LOCK_CNT) begin
            // The lock-declaring comma is emitted as the first word.
            w_state_next = LOCKED;
            w_emit       = 1'b1;
          end
        end else if (w_mis_any) begin
          w_sel_next   = w_mis_sel;
          w_phase_next = 3'd1;
          w_good_next  = 4'd1;
        end
      end

      LOCKED: begin
        w_emit = w_boundary;
        if (w_aligned) begin
          w_bad_next = 4'd0;
        end else if (w_mis_any) begin
          if (w_bad_inc >= UNLOCK_CNT) begin
            w_state_next = HUNT;
            w_bad_next   = 4'd0;
            w_good_next  = 4'd0;
          end else begin
            w_bad_next = w_bad_inc;
          end
        end
      end

      default: begin
        w_state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_ser) begin
    if (reset) begin
      r_state    <= HUNT;
      r_sel      <= 1'b0;
      r_phase    <= 3'd0;
      r_good_cnt <= 4'd0;
      r_bad_cnt  <= 4'd0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_is_comma <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sel      <= w_sel_next;
      r_phase    <= w_phase_next;
      r_good_cnt <= w_good_next;
      r_bad_cnt  <= w_bad_next;
      r_valid    <= w_emit;
      r_locked   <= (w_state_next == LOCKED);
      r_is_comma <= w_emit && w_emit_comma;
      if (w_emit) begin
        r_word <= w_emit_word;
      end
    end
  end

  assign parOutWord  = r_word;
  assign parOutValid = r_valid;
  assign locked      = r_locked;
  assign isComma     = r_is_comma;

`ifdef TIMING_DESER_ERRCNT_EN
  // -------------------------------------------------------------------------
  // Saturating mis-aligned comma counter, cleared only by reset.
  // -------------------------------------------------------------------------
  logic [15:0] r_misalign_cnt;
  logic        w_mis_err;

  assign w_mis_err = (r_state == LOCKED) && w_mis_any;

  always_ff @(posedge clk_ser) begin
    if (reset) begin
      r_misalign_cnt <= 16'd0;
    end else if (w_mis_err && (r_misalign_cnt != 16'hFFFF)) begin
      r_misalign_cnt <= r_misalign_cnt + 16'd1;
    end
  end

  assign misalignCnt = r_misalign_cnt;
`endif

endmodule

// File: tb/tb_timing_deserializer.sv
// ---------------------------------------------------------------------------
// tb_timing_deserializer
//   Directed bench for timing_deserializer: streams are built as bit queues
//   (serializer order, bit 9 first), fed one pair per clock, and lock timing,
//   emitted words and strobe spacing are compared against hand-derived values.
//   Works with or without TIMING_DESER_ERRCNT_EN.
// ---------------------------------------------------------------------------
module tb_timing_deserializer;
  import timingPkg::*;

  logic        clk_ser = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  serInPair = 2'b00;
  logic [9:0]  parOutWord;
  logic        parOutValid;
  logic        locked;
  logic        isComma;
`ifdef TIMING_DESER_ERRCNT_EN
  logic [15:0] misalignCnt;
`endif

  timing_deserializer #(
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (4)
  ) dut (
    .clk_ser     (clk_ser),
    .reset       (reset),
    .serInPair   (serInPair),
    .parOutWord  (parOutWord),
    .parOutValid (parOutValid),
    .locked      (locked),
    .isComma     (isComma)
`ifdef TIMING_DESER_ERRCNT_EN
    ,
    .misalignCnt (misalignCnt)
`endif
  );

  always #5 clk_ser = ~clk_ser;

  localparam logic [9:0] W2AA = 10'h2AA;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         base = 0;
  int         lock_rise_cyc;
  int         lock_fall_cyc;
  int         last_valid_cyc;
  int         valid_count;
  int         spacing_bad;
  logic [9:0] first_word;
  logic [9:0] last_word;
  logic       first_is_comma;
  logic       last_is_comma;
  logic       first_pending;
  logic       prev_locked;
  logic       bit_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive pair, sample #1 after the edge, update observations.
  task automatic step(input logic [1:0] pair, input logic rst);
    reset     = rst;
    serInPair = pair;
    @(posedge clk_ser);
    #1;
    cyc++;
    if (locked && !prev_locked) begin
      lock_rise_cyc  = cyc;
      last_valid_cyc = -1;
      first_pending  = 1'b1;
    end
    if (!locked && prev_locked) lock_fall_cyc = cyc;
    if (parOutValid) begin
      if (first_pending) begin
        first_word     = parOutWord;
        first_is_comma = isComma;
        first_pending  = 1'b0;
      end
      if (last_valid_cyc >= 0 && (cyc - last_valid_cyc) != 5) spacing_bad++;
      last_valid_cyc = cyc;
      valid_count++;
      last_word      = parOutWord;
      last_is_comma  = isComma;
    end
    prev_locked = locked;
  endtask

  task automatic push_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) bit_q.push_back(w[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) bit_q.push_back(1'b0);
  endtask

  task automatic feed_pairs(input int n);
    logic b1;
    logic b0;
    for (int i = 0; i < n; i++) begin
      b1 = (bit_q.size() > 0) ? bit_q.pop_front() : 1'b0;
      b0 = (bit_q.size() > 0) ? bit_q.pop_front() : 1'b0;
      step({b1, b0}, 1'b0);
    end
  endtask

  task automatic flush();
    feed_pairs((bit_q.size() + 1) / 2);
  endtask

  task automatic clear_stats();
    base           = cyc;
    lock_rise_cyc  = -1;
    lock_fall_cyc  = -1;
    last_valid_cyc = -1;
    valid_count    = 0;
    spacing_bad    = 0;
    first_word     = '0;
    last_word      = '0;
    first_is_comma = 1'b0;
    last_is_comma  = 1'b0;
    first_pending  = 1'b0;
    prev_locked    = locked;
  endtask

  task automatic do_reset();
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    bit_q.delete();
    clear_stats();
  endtask

  initial begin
    prev_locked = 1'b0;

    // ---------------- Reset state ----------------
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_valid", parOutValid, 0);
    chk("rst_word", parOutWord, 0);
    chk("rst_isComma", isComma, 0);
`ifdef TIMING_DESER_ERRCNT_EN
    chk("rst_misalignCnt", misalignCnt, 0);
`endif

    // ---------------- Even alignment ----------------
    // Commas complete at edges 4,9,14,19; lock declared at 19, visible at 20.
    for (int i = 0; i < 4; i++) push_word(K28P5_RDN);
    for (int i = 0; i < 6; i++) push_word(W2AA);
    flush();
    chk("even_lock_cycle", lock_rise_cyc, base + 21);
    chk("even_first_word", first_word, K28P5_RDN);
    chk("even_first_isComma", first_is_comma, 1);
    chk("even_last_word", last_word, W2AA);
    chk("even_last_isComma", last_is_comma, 0);
    chk("even_spacing", spacing_bad, 0);
    chk("even_valid_count", valid_count, 6);
    chk("even_locked", locked, 1);

    // ---------------- Odd alignment ----------------
    do_reset();
    push_zeros(1);
    for (int i = 0; i < 4; i++) push_word(K28P5_RDN);
    for (int i = 0; i < 6; i++) push_word(W2AA);
    push_zeros(1);
    flush();
    chk("odd_lock_cycle", lock_rise_cyc, base + 22);
    chk("odd_first_word", first_word, K28P5_RDN);
    chk("odd_last_word", last_word, W2AA);
    chk("odd_spacing", spacing_bad, 0);
    chk("odd_valid_count", valid_count, 6);

    // ---------------- Verify restart after 2-bit slip ----------------
    // Slipped comma at edge 15 re-aligns; 4th post-slip comma at edge 30.
    do_reset();
    push_word(K28P5_RDN);
    push_word(K28P5_RDN);
    push_zeros(2);
    for (int i = 0; i < 4; i++) push_word(K28P5_RDN);
    for (int i = 0; i < 4; i++) push_word(W2AA);
    flush();
    chk("slip_lock_cycle", lock_rise_cyc, base + 32);
    chk("slip_first_word", first_word, K28P5_RDN);
    chk("slip_last_word", last_word, W2AA);
    chk("slip_valid_count", valid_count, 4);

    // ---------------- Unlock then relock ----------------
    // Mis-aligned commas at edges 30,36,42,48 -> locked falls at 49.
    // Stream continues at the new alignment: commas at 53,58,63,68 -> relock 69.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(K28P5_RDN);
    push_word(W2AA);
    for (int i = 0; i < 4; i++) begin
      push_zeros(2);
      push_word(K28P5_RDN);
    end
    for (int i = 0; i < 5; i++) push_word(K28P5_RDN);
    push_word(W2AA);
    push_word(W2AA);
    flush();
    chk("unlock_fall_cycle", lock_fall_cyc, base + 50);
    chk("relock_cycle", lock_rise_cyc, base + 70);
    chk("relock_last_word", last_word, W2AA);
    chk("relock_locked", locked, 1);
`ifdef TIMING_DESER_ERRCNT_EN
    chk("unlock_misalignCnt", misalignCnt, 4);
`endif

    // ---------------- badCnt clear by aligned comma ----------------
    // 3 mis-aligned, one aligned RD+ comma at edge 49, 3 more mis-aligned.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(K28P5_RDN);
    push_word(W2AA);
    for (int i = 0; i < 3; i++) begin
      push_zeros(2);
      push_word(K28P5_RDN);
    end
    push_zeros(4);
    push_word(K28P5_RDP);
    for (int i = 0; i < 3; i++) begin
      push_zeros(2);
      push_word(K28P5_RDN);
    end
    flush();
    chk("badclr_locked", locked, 1);
    chk("badclr_no_fall", lock_fall_cyc, -1);
    chk("badclr_valid_count", valid_count, 10);
    chk("badclr_spacing", spacing_bad, 0);
`ifdef TIMING_DESER_ERRCNT_EN
    chk("badclr_misalignCnt", misalignCnt, 6);
`endif

    // ---------------- Reset mid-operation at phase 2 ----------------
    do_reset();
    for (int i = 0; i < 4; i++) push_word(K28P5_RDN);
    push_word(W2AA);
    push_word(W2AA);
    feed_pairs(27);
    chk("mid_pre_locked", locked, 1);
    chk("mid_pre_word", parOutWord, W2AA);
    step(2'b00, 1'b1);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_valid", parOutValid, 0);
    chk("mid_rst_word", parOutWord, 0);
    chk("mid_rst_isComma", isComma, 0);
`ifdef TIMING_DESER_ERRCNT_EN
    chk("mid_rst_misalignCnt", misalignCnt, 0);
`endif
    bit_q.delete();
    clear_stats();
    for (int i = 0; i < 4; i++) push_word(K28P5_RDN);
    for (int i = 0; i < 3; i++) push_word(W2AA);
    flush();
    chk("mid_relock_cycle", lock_rise_cyc, base + 21);
    chk("mid_relock_last_word", last_word, W2AA);
    chk("mid_relock_valid_count", valid_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
